// File: rtl/piano_tiles_pkg.sv
// Shared constants for the piano-tiles display path: 3-3-3 RGB colours,
// drawer state encoding and default coordinate widths.
package piano_tiles_pkg;

  localparam int X_W_DEF     = 10;
  localparam int Y_W_DEF     = 9;
  localparam int COLOR_W_DEF = 9;

  localparam logic [8:0] TILE_COLOR = 9'h000;
  localparam logic [8:0] BG_COLOR   = 9'h1FF;
  localparam logic [8:0] GRID_COLOR = 9'h092;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_DRAW,
    ST_DONE
  } draw_state_e;

endpackage

// File: rtl/tile_pixel_scanner.sv
// Cell-local raster counters: px runs fastest, last flags the final pixel of a tile.
module tile_pixel_scanner #(
  parameter int TILE_W = 40,
  parameter int TILE_H = 30,
  parameter int PX_W   = $clog2(TILE_W > 1 ? TILE_W : 2),
  parameter int PY_W   = $clog2(TILE_H > 1 ? TILE_H : 2)
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            clear,
  input  logic            enable,
  output logic [PX_W-1:0] px,
  output logic [PY_W-1:0] py,
  output logic            last
);

  logic [PX_W-1:0] px_q;
  logic [PY_W-1:0] py_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      px_q <= '0;
      py_q <= '0;
    end else if (clear) begin
      px_q <= '0;
      py_q <= '0;
    end else if (enable) begin
      if (px_q == PX_W'(TILE_W - 1)) begin
        px_q <= '0;
        py_q <= (py_q == PY_W'(TILE_H - 1)) ? '0 : py_q + PY_W'(1);
      end else begin
        px_q <= px_q + PX_W'(1);
      end
    end
  end

  assign px   = px_q;
  assign py   = py_q;
  assign last = (px_q == PX_W'(TILE_W - 1)) && (py_q == PY_W'(TILE_H - 1));

endmodule

// File: rtl/tile_board_drawer.sv
// Renders a LANES x ROWS tile board into the VGA adapter write port, one pixel
// per clock, repainting only changed cells. Define TILE_GRID_EN for grid lines.
module tile_board_drawer
  import piano_tiles_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int ROWS    = 4,
  parameter int TILE_W  = 40,
  parameter int TILE_H  = 30,
  parameter int X0      = 0,
  parameter int Y0      = 0,
  parameter int X_W     = X_W_DEF,
  parameter int Y_W     = Y_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   full,
  input  logic [LANES*ROWS-1:0]  board,
  output logic                   busy,
  output logic                   done,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [COLOR_W-1:0]     color,
  output logic                   plot
);

  localparam int CELLS  = LANES * ROWS;
  localparam int CELL_W = $clog2(CELLS > 1 ? CELLS : 2);
  localparam int LANE_W = $clog2(LANES > 1 ? LANES : 2);
  localparam int PX_W   = $clog2(TILE_W > 1 ? TILE_W : 2);
  localparam int PY_W   = $clog2(TILE_H > 1 ? TILE_H : 2);

  draw_state_e          state_q;
  logic [CELLS-1:0]     cur_q, prev_q;
  logic                 force_q, force_pending_q;
  logic [LANE_W-1:0]    lane_q;
  logic [CELL_W-1:0]    cell_q;
  logic [X_W-1:0]       xbase_q, x_q;
  logic [Y_W-1:0]       ybase_q, y_q;
  logic [COLOR_W-1:0]   color_q;
  logic                 plot_q, busy_q, done_q;

  logic [PX_W-1:0]      px;
  logic [PY_W-1:0]      py;
  logic                 scan_last;

  tile_pixel_scanner #(
    .TILE_W (TILE_W),
    .TILE_H (TILE_H),
    .PX_W   (PX_W),
    .PY_W   (PY_W)
  ) u_scanner (
    .clock  (clock),
    .resetn (resetn),
    .clear  (state_q == ST_SELECT),
    .enable (state_q == ST_DRAW),
    .px     (px),
    .py     (py),
    .last   (scan_last)
  );

  logic               cell_bit, dirty, last_cell, lane_last, row_wrap;
  logic [COLOR_W-1:0] cell_color, first_color, step_color;
  logic [LANE_W-1:0]  lane_d;
  logic [X_W-1:0]     xbase_d;
  logic [Y_W-1:0]     ybase_d;

  always_comb begin
    cell_bit   = cur_q[cell_q];
    dirty      = force_q | (cell_bit ^ prev_q[cell_q]);
    last_cell  = (cell_q == CELL_W'(CELLS - 1));
    lane_last  = (lane_q == LANE_W'(LANES - 1));
    row_wrap   = (px == PX_W'(TILE_W - 1));
    cell_color = cell_bit ? COLOR_W'(TILE_COLOR) : COLOR_W'(BG_COLOR);
`ifdef TILE_GRID_EN
    // Colour is for the pixel after the current one: it lands on px==0 after a
    // row wrap, and on py==0 anywhere in the first row.
    first_color = COLOR_W'(GRID_COLOR);
    step_color  = (row_wrap || (py == '0)) ? COLOR_W'(GRID_COLOR) : cell_color;
`else
    first_color = cell_color;
    step_color  = cell_color;
`endif
    // Base accumulators step one tile right, or back to X0 and one tile down.
    lane_d  = lane_last ? '0 : lane_q + LANE_W'(1);
    xbase_d = lane_last ? X_W'(X0) : xbase_q + X_W'(TILE_W);
    ybase_d = lane_last ? ybase_q + Y_W'(TILE_H) : ybase_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q         <= ST_IDLE;
      cur_q           <= '0;
      prev_q          <= '0;
      force_q         <= 1'b0;
      force_pending_q <= 1'b1;
      lane_q          <= '0;
      cell_q          <= '0;
      xbase_q         <= '0;
      ybase_q         <= '0;
      x_q             <= '0;
      y_q             <= '0;
      color_q         <= '0;
      plot_q          <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cur_q   <= board;
            force_q <= full | force_pending_q;
            lane_q  <= '0;
            cell_q  <= '0;
            xbase_q <= X_W'(X0);
            ybase_q <= Y_W'(Y0);
            busy_q  <= 1'b1;
            state_q <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (dirty) begin
            state_q <= ST_DRAW;
            plot_q  <= 1'b1;
            x_q     <= xbase_q;
            y_q     <= ybase_q;
            color_q <= first_color;
          end else if (last_cell) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            lane_q  <= lane_d;
            cell_q  <= cell_q + CELL_W'(1);
            xbase_q <= xbase_d;
            ybase_q <= ybase_d;
          end
        end
        ST_DRAW: begin
          if (scan_last) begin
            plot_q <= 1'b0;
            if (last_cell) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_SELECT;
              lane_q  <= lane_d;
              cell_q  <= cell_q + CELL_W'(1);
              xbase_q <= xbase_d;
              ybase_q <= ybase_d;
            end
          end else begin
            color_q <= step_color;
            if (row_wrap) begin
              x_q <= xbase_q;
              y_q <= ybase_q + Y_W'(py) + Y_W'(1);
            end else begin
              x_q <= x_q + X_W'(1);
            end
          end
        end
        ST_DONE: begin
          state_q         <= ST_IDLE;
          busy_q          <= 1'b0;
          done_q          <= 1'b0;
          prev_q          <= cur_q;
          force_pending_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign x     = x_q;
  assign y     = y_q;
  assign color = color_q;
  assign plot  = plot_q;

endmodule
